bcd_operand_entry: RTL

- Input-side counterpart of the binary-to-BCD display path: the operator enters a 5-digit decimal operand with pushbuttons.
- The block holds the digits as BCD, which can drive the 7-segment display directly.
- On request it converts the BCD digits sequentially into a 16-bit binary operand for the ALU, with a valid pulse and an overflow flag.
- Sits between the board buttons and the ALU A/B operand registers.

---
 rtl/bcd_operand_entry.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_operand_entry.sv
// Pushbutton entry of a 5-digit BCD operand with sequential BCD-to-binary conversion.
// Optional build macro AUTO_CONVERT_EN: every digit or cursor edit also launches a conversion.

module bcd_operand_entry_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_event
);

    logic        r_sync0;
    logic        r_sync1;
    logic        r_level;
    logic        r_level_d;
    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
        end
    end

    // The counter runs only while the synchronized input disagrees with the
    // debounced level; a single agreeing cycle (bounce) restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_count <= 16'd0;
        end else if (r_sync1 != r_level) begin
            if (r_count == DEBOUNCE_CYCLES - 16'd1) begin
                r_level <= r_sync1;
                r_count <= 16'd0;
            end else begin
                r_count <= r_count + 16'd1;
            end
        end else begin
            r_count <= 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= r_level;
        end
    end

    assign o_event = r_level & ~r_level_d;

endmodule

module bcd_operand_entry #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          NUM_DIGITS      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_inc,
    input  logic        btn_sel,
    input  logic        btn_enter,
    output logic [19:0] bcd_digits,
    output logic [2:0]  cursor,
    output logic [15:0] value,
    output logic        valid,
    output logic        overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_EDIT    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        w_inc_ev;
    logic        w_sel_ev;
    logic        w_ent_ev;

    logic [19:0] r_digits;
    logic [2:0]  r_cursor;
    logic [19:0] w_digits_edit;
    logic [2:0]  w_cursor_edit;
    logic        w_apply_edit;
    logic        w_start;
    logic [19:0] w_snap_src;

    logic [19:0] r_snap;
    logic [16:0] r_acc;
    logic [2:0]  r_idx;
    logic [3:0]  w_digit_sel;
    logic [16:0] w_acc_next;

    logic [15:0] r_value;
    logic        r_overflow;

    bcd_operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_inc),
        .o_event (w_inc_ev)
    );

    bcd_operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_sel),
        .o_event (w_sel_ev)
    );

    bcd_operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ent (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_enter),
        .o_event (w_ent_ev)
    );

    // Candidate edit: increment uses the current cursor even when the cursor
    // advances in the same cycle.
    always_comb begin
        w_digits_edit = r_digits;
        for (int i = 0; i < 5; i++) begin
            if (w_inc_ev && (r_cursor == 3'(i))) begin
                w_digits_edit[i*4 +: 4] = (r_digits[i*4 +: 4] == 4'd9) ?
                                          4'd0 : r_digits[i*4 +: 4] + 4'd1;
            end
        end
        w_cursor_edit = r_cursor;
        if (w_sel_ev) begin
            w_cursor_edit = (r_cursor == 3'd4) ? 3'd0 : r_cursor + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EDIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_apply_edit = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            ST_EDIT: begin
                if (w_ent_ev) begin
                    w_start      = 1'b1;
                    w_state_next = ST_CONVERT;
                end else if (w_inc_ev || w_sel_ev) begin
                    w_apply_edit = 1'b1;
`ifdef AUTO_CONVERT_EN
                    w_start      = 1'b1;
                    w_state_next = ST_CONVERT;
`endif
                end
            end
            ST_CONVERT: begin
                if (r_idx == 3'd0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_EDIT;
            end
            default: begin
                w_state_next = ST_EDIT;
            end
        endcase
    end

    // Enter snapshots the unedited digits; an auto-launched conversion sees
    // the digits after this cycle's edit.
    assign w_snap_src = w_ent_ev ? r_digits : w_digits_edit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 20'd0;
            r_cursor <= 3'd0;
        end else if (w_apply_edit) begin
            r_digits <= w_digits_edit;
            r_cursor <= w_cursor_edit;
        end
    end

    always_comb begin
        case (r_idx)
            3'd4:    w_digit_sel = r_snap[19:16];
            3'd3:    w_digit_sel = r_snap[15:12];
            3'd2:    w_digit_sel = r_snap[11:8];
            3'd1:    w_digit_sel = r_snap[7:4];
            default: w_digit_sel = r_snap[3:0];
        endcase
    end

    assign w_acc_next = (r_acc * 17'd10) + {13'd0, w_digit_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= 20'd0;
            r_acc  <= 17'd0;
            r_idx  <= 3'd0;
        end else if (w_start) begin
            r_snap <= w_snap_src;
            r_acc  <= 17'd0;
            r_idx  <= LAST_IDX;
        end else if (r_state == ST_CONVERT) begin
            r_acc <= w_acc_next;
            if (r_idx != 3'd0) begin
                r_idx <= r_idx - 3'd1;
            end
        end
    end

    // The result is registered on the final digit step so that value and
    // overflow are already updated during the DONE cycle that pulses valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value    <= 16'd0;
            r_overflow <= 1'b0;
        end else if ((r_state == ST_CONVERT) && (r_idx == 3'd0)) begin
            if (w_acc_next > 17'd65535) begin
                r_value    <= 16'hFFFF;
                r_overflow <= 1'b1;
            end else begin
                r_value    <= w_acc_next[15:0];
                r_overflow <= 1'b0;
            end
        end
    end

    assign bcd_digits = r_digits;
    assign cursor     = r_cursor;
    assign value      = r_value;
    assign overflow   = r_overflow;
    assign valid      = (r_state == ST_DONE);
    assign busy       = (r_state != ST_EDIT);

endmodule
